// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the load/store path of the core.
// Holds the RV32I load/store funct3 codes, the LSU FSM state type and
// two decode helpers that classify an incoming memory operation.
package riscv_pkg;

  // RV32I load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  // True when exactly one direction is set and funct3 names a width that
  // the direction supports.
  function automatic logic lsu_op_legal(input logic       is_load,
                                        input logic       is_store,
                                        input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_load && !is_store) begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end else if (is_store && !is_load) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // funct3[1:0] encodes the access size for every legal code, so natural
  // alignment only needs the low address bits against that size.
  function automatic logic lsu_op_aligned(input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
    logic ok;
    case (f3[1:0])
      2'b01:   ok = (addr_lo[0] == 1'b0);
      2'b10:   ok = (addr_lo == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load data extraction.
// Picks the addressed byte/halfword out of the returned memory word and
// sign- or zero-extends it according to funct3; LW passes the word through.
// Ports:
//   rdata_i   - raw word returned by data memory
//   addr_lo_i - low two bits of the effective address
//   funct3_i  - load width/sign code
//   data_o    - extended load result
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_s = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH:   data_o = {{(XLEN-16){half_s[15]}}, half_s};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_s};
      F3_LW:   data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: execute-to-memory stage.
// Accepts one load/store from execute, rejects illegal or misaligned ops
// locally with an error completion, otherwise runs a req/gnt/rvalid
// transaction on the data memory port and returns extended load data.
// Ports:
//   ex_*    - operation handshake from execute (valid/ready, direction,
//             funct3, effective address, store data)
//   done    - one-cycle completion pulse; rdata valid for loads, err/err_addr
//             valid for rejected ops
//   dmem_*  - data memory request/grant/response interface
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_load,
  input  logic            ex_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic [XLEN-1:0] err_addr,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  lsu_state_t      state_q;
  logic [1:0]      addr_lo_q;
  logic [2:0]      funct3_q;
  logic            is_load_q;
  logic            done_q;
  logic            err_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] err_addr_q;
  logic            dmem_req_q;
  logic            dmem_we_q;
  logic [XLEN-1:0] dmem_addr_q;
  logic [XLEN-1:0] dmem_wdata_q;
  logic [3:0]      dmem_be_q;

  logic            op_ok_s;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] load_data_s;

  assign op_ok_s = lsu_op_legal(ex_load, ex_store, ex_funct3) &&
                   lsu_op_aligned(ex_funct3, ex_addr[1:0]);

  // Store lane steering: data is replicated across lanes so memory only has
  // to honour the byte enables. Loads always fetch the full word.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = {XLEN{1'b0}};
    if (ex_store) begin
      case (ex_funct3)
        F3_SB: begin
          be_d    = 4'b0001 << ex_addr[1:0];
          wdata_d = {4{ex_wdata[7:0]}};
        end
        F3_SH: begin
          be_d    = ex_addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{ex_wdata[15:0]}};
        end
        F3_SW: begin
          be_d    = 4'b1111;
          wdata_d = ex_wdata;
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = ex_wdata;
        end
      endcase
    end else begin
      be_d    = 4'b1111;
      wdata_d = {XLEN{1'b0}};
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (load_data_s)
  );

  // Transaction FSM with registered memory-side and completion outputs.
  // done/err are single-cycle pulses; rdata/err_addr hold between completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_lo_q    <= 2'b00;
      funct3_q     <= 3'b000;
      is_load_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= {XLEN{1'b0}};
      err_addr_q   <= {XLEN{1'b0}};
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= {XLEN{1'b0}};
      dmem_wdata_q <= {XLEN{1'b0}};
      dmem_be_q    <= 4'b0000;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            addr_lo_q <= ex_addr[1:0];
            funct3_q  <= ex_funct3;
            is_load_q <= ex_load;
            if (op_ok_s) begin
              state_q      <= REQ;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= ex_store;
              dmem_addr_q  <= {ex_addr[XLEN-1:2], 2'b00};
              dmem_wdata_q <= wdata_d;
              dmem_be_q    <= be_d;
            end else begin
              // Rejected locally: memory never sees it.
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_addr_q <= ex_addr;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (is_load_q) begin
              state_q <= WAIT;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            rdata_q <= load_data_s;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready   = (state_q == IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign err_addr   = err_addr_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_be    = dmem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        done, err;
  logic [31:0] rdata, err_addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .done(done), .rdata(rdata), .err(err), .err_addr(err_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one op for exactly one accept edge; returns in cycle 1.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd;
    cyc = 0;
    tick();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b000;
    ex_addr = 32'h0; ex_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (ex_ready !== 1'b1) begin n_mis++; $display("FAIL reset_ready got %b want 1", ex_ready); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_mis++; $display("FAIL reset_req got %b want 0", dmem_req); end
    n_cmp++; if (dmem_we !== 1'b0) begin n_mis++; $display("FAIL reset_we got %b want 0", dmem_we); end
    n_cmp++; if ({dmem_addr, dmem_wdata, dmem_be} !== 68'h0) begin n_mis++; $display("FAIL reset_dmem got %h/%h/%b want 0", dmem_addr, dmem_wdata, dmem_be); end
    n_cmp++; if ({done, err} !== 2'b00) begin n_mis++; $display("FAIL reset_done_err got %b%b want 00", done, err); end
    n_cmp++; if ({rdata, err_addr} !== 64'h0) begin n_mis++; $display("FAIL reset_data got %h/%h want 0", rdata, err_addr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(1'b0, 1'b1, f3, a, wd);
    n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin n_mis++; $display("FAIL %s_req got req=%b we=%b want 1/1", nm, dmem_req, dmem_we); end
    n_cmp++; if (dmem_addr !== exp_addr) begin n_mis++; $display("FAIL %s_addr got %h want %h", nm, dmem_addr, exp_addr); end
    n_cmp++; if (dmem_be !== exp_be) begin n_mis++; $display("FAIL %s_be got %b want %b", nm, dmem_be, exp_be); end
    n_cmp++; if (dmem_wdata !== exp_wd) begin n_mis++; $display("FAIL %s_wdata got %h want %h", nm, dmem_wdata, exp_wd); end
    n_cmp++; if (done !== 1'b0 || ex_ready !== 1'b0) begin n_mis++; $display("FAIL %s_busy got done=%b ready=%b want 0/0", nm, done, ex_ready); end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    n_cmp++; if (done !== 1'b1 || err !== 1'b0 || cyc != 2) begin n_mis++; $display("FAIL %s_done got done=%b err=%b cyc=%0d want 1/0/2", nm, done, err, cyc); end
    n_cmp++; if (dmem_req !== 1'b0 || ex_ready !== 1'b1) begin n_mis++; $display("FAIL %s_idle got req=%b ready=%b want 0/1", nm, dmem_req, ex_ready); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL %s_single_done got %b want 0", nm, done); end
  endtask

  // k cycles of withheld grant, rvalid m cycles after the grant cycle.
  task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp_addr, input logic [31:0] word,
                           input logic [31:0] exp, input int k, input int m);
    issue(1'b1, 1'b0, f3, a, 32'hFFFF_FFFF);
    for (int i = 0; i < k; i++) begin
      n_cmp++; if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_be !== 4'b1111) begin n_mis++; $display("FAIL %s_hold%0d got req=%b addr=%h be=%b want 1/%h/1111", nm, i, dmem_req, dmem_addr, dmem_be, exp_addr); end
      tick();
    end
    n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== exp_addr || dmem_be !== 4'b1111 || dmem_wdata !== 32'h0) begin n_mis++; $display("FAIL %s_req got req=%b we=%b addr=%h be=%b wd=%h want 1/0/%h/1111/0", nm, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, exp_addr); end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    for (int i = 1; i < m; i++) begin
      n_cmp++; if (dmem_req !== 1'b0 || done !== 1'b0) begin n_mis++; $display("FAIL %s_wait%0d got req=%b done=%b want 0/0", nm, i, dmem_req, done); end
      tick();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = word;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'hBAD0_BAD0;
    n_cmp++; if (done !== 1'b1 || err !== 1'b0 || cyc != 2 + k + m) begin n_mis++; $display("FAIL %s_done got done=%b err=%b cyc=%0d want 1/0/%0d", nm, done, err, cyc, 2 + k + m); end
    n_cmp++; if (rdata !== exp) begin n_mis++; $display("FAIL %s_rdata got %h want %h", nm, rdata, exp); end
    tick();
    n_cmp++; if (done !== 1'b0 || rdata !== exp) begin n_mis++; $display("FAIL %s_after got done=%b rdata=%h want 0/%h", nm, done, rdata, exp); end
  endtask

  task automatic test_error(input string nm, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] a);
    issue(ld, st, f3, a, 32'h5555_5555);
    n_cmp++; if (done !== 1'b1 || err !== 1'b1) begin n_mis++; $display("FAIL %s_err got done=%b err=%b want 1/1", nm, done, err); end
    n_cmp++; if (err_addr !== a) begin n_mis++; $display("FAIL %s_err_addr got %h want %h", nm, err_addr, a); end
    n_cmp++; if (dmem_req !== 1'b0 || ex_ready !== 1'b1) begin n_mis++; $display("FAIL %s_noreq got req=%b ready=%b want 0/1", nm, dmem_req, ex_ready); end
    tick();
    n_cmp++; if (done !== 1'b0 || err !== 1'b0 || dmem_req !== 1'b0 || err_addr !== a) begin n_mis++; $display("FAIL %s_after got done=%b err=%b req=%b ea=%h want 0/0/0/%h", nm, done, err, dmem_req, err_addr, a); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] prev_rdata;
    prev_rdata = rdata;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (dmem_req !== 1'b0 || done !== 1'b0 || ex_ready !== 1'b1) begin n_mis++; $display("FAIL rst_wait got req=%b done=%b ready=%b want 0/0/1", dmem_req, done, ex_ready); end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    n_cmp++; if (done !== 1'b0 || rdata !== 32'h0) begin n_mis++; $display("FAIL rst_late_rvalid got done=%b rdata=%h (prev %h) want 0/00000000", done, rdata, prev_rdata); end
    tick();
    test_load("rst_lw", 3'b010, 32'h0, 32'h0, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 0, 1);
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h1111_2222);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    n_cmp++; if (done !== 1'b1 || ex_ready !== 1'b1) begin n_mis++; $display("FAIL b2b_first got done=%b ready=%b want 1/1", done, ex_ready); end
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_003C);
    n_cmp++; if (done !== 1'b0 || dmem_req !== 1'b1 || dmem_be !== 4'b0010 || dmem_wdata !== 32'h3C3C_3C3C) begin n_mis++; $display("FAIL b2b_second got done=%b req=%b be=%b wd=%h want 0/1/0010/3c3c3c3c", done, dmem_req, dmem_be, dmem_wdata); end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    n_cmp++; if (done !== 1'b1 || cyc != 2) begin n_mis++; $display("FAIL b2b_done got done=%b cyc=%0d want 1/2", done, cyc); end
    tick();
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b000;
    ex_addr = 32'h0; ex_wdata = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    dmem_rdata = 32'hBAD0_BAD0; cyc = 0;
    #1;
    test_reset();
    test_store("sw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    test_store("sb", 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
    test_store("sh_hi", 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0000_0100, 4'b1100, 32'h1234_1234);
    test_store("sh_lo", 3'b001, 32'h0000_0100, 32'hABCD_5678, 32'h0000_0100, 4'b0011, 32'h5678_5678);
    test_load("lb", 3'b000, 32'h0000_0202, 32'h0000_0200, 32'h1280_3456, 32'hFFFF_FF80, 0, 1);
    test_load("lbu", 3'b100, 32'h0000_0202, 32'h0000_0200, 32'h1280_3456, 32'h0000_0080, 0, 1);
    test_load("lh", 3'b001, 32'h0000_0202, 32'h0000_0200, 32'h1280_3456, 32'h0000_1280, 0, 1);
    test_load("lw", 3'b010, 32'h0000_0200, 32'h0000_0200, 32'h1280_3456, 32'h1280_3456, 0, 1);
    test_load("lb1", 3'b000, 32'h0000_0201, 32'h0000_0200, 32'h1280_3456, 32'h0000_0034, 0, 1);
    test_load("lh_neg", 3'b001, 32'h0000_0200, 32'h0000_0200, 32'h0000_F00D, 32'hFFFF_F00D, 0, 1);
    test_load("lhu", 3'b101, 32'h0000_0200, 32'h0000_0200, 32'h0000_F00D, 32'h0000_F00D, 0, 1);
    test_load("slow_lw", 3'b010, 32'h0000_0404, 32'h0000_0404, 32'hCAFE_0001, 32'hCAFE_0001, 2, 2);
    test_error("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0102);
    test_error("sh_mis", 1'b0, 1'b1, 3'b001, 32'h0000_0101);
    test_error("ld_f3", 1'b1, 1'b0, 3'b011, 32'h0000_0104);
    test_error("st_f3", 1'b0, 1'b1, 3'b100, 32'h0000_0108);
    test_error("both", 1'b1, 1'b1, 3'b010, 32'h0000_010C);
    test_error("none", 1'b0, 1'b0, 3'b010, 32'h0000_0110);
    test_reset_in_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Execute-to-memory stage of the RISC-V core. Sits directly downstream of the ALU: it consumes the ALU result as the effective address, plus rs2 as store data, and runs a valid/grant/rvalid transaction to data memory. It returns aligned and sign- or zero-extended load data for writeback. Misaligned accesses and illegal accesses are flagged and never reach memory.

## Interface
Parameters:
- XLEN, 32, datapath and address width. Only 32 is supported.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  memory op presented; held stable until accepted
- ex_ready  out  1  LSU can accept; equals (state==IDLE)
- ex_load  in  1  op is a load
- ex_store  in  1  op is a store
- ex_funct3  in  3  RV32I width/sign code
- ex_addr  in  32  effective address (ALU result)
- ex_wdata  in  32  store data (rs2)
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load data; valid with done and load
- err  out  1  with done: access rejected
- err_addr  out  32  faulting address; valid with err
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, with ex_valid (accept):
  - Latch addr, funct3, direction.
  - A legal, aligned op goes to REQ.
  - Otherwise stay in IDLE and pulse done=1 with err=1 and err_addr=ex_addr on the next cycle. No dmem_req is issued.
- Illegal cases:
  - ex_load==ex_store, both 0 or both 1.
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
- Misaligned cases:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- REQ:
  - dmem_req=1. dmem_we, dmem_addr, dmem_wdata and dmem_be are held constant until dmem_gnt.
  - On gnt, a store goes to IDLE and asserts done next cycle.
  - On gnt, a load goes to WAIT.
- WAIT: on dmem_rvalid, go to IDLE, with done=1 and rdata=extended data next cycle.
- dmem_rvalid is ignored outside WAIT.
- Store lanes:
  - SB: be = 4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata={2{rs2[15:0]}}.
  - SW: be = 1111, wdata=rs2.
- Load requests: we=0, be=1111, wdata=0.
- Load extraction: byte lane = addr[1:0]*8, halfword lane = addr[1]*16.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- done, rdata, err and err_addr are registered. rdata and err_addr hold until the next done.

## Timing
- Reset values:
  - state=IDLE, so ex_ready=1.
  - dmem_req=0, dmem_we=0.
  - dmem_addr, dmem_wdata, dmem_be = 0.
  - done=0, err=0.
  - rdata, err_addr = 0.
- Cycle 0: accept. Cycle 1: dmem_req high.
- Store latency: gnt at cycle 1+k, then done at cycle 2+k.
- Load latency: gnt at cycle 1+k, rvalid at cycle 1+k+m with m≥1, then done one cycle after rvalid.
- Best case: store done at cycle 2, load done at cycle 3.
- Error latency: done/err at cycle 1.
- Memory rules:
  - Memory must not assert rvalid in the same cycle as gnt.
  - Exactly one rvalid per load.
- done never asserts for two consecutive ops without an intervening accept.
- ex_ready=1 during the done cycle, so back-to-back accept is allowed.
- rst in REQ or WAIT:
  - Transaction abandoned, dmem_req=0 the next cycle, no done.
  - A late rvalid after reset is ignored because state is IDLE.

## Structure
- Shared package riscv_pkg holds:
  - funct3 constants F3_LB/LH/LW/LBU/LHU and F3_SB/SH/SW.
  - lsu_state_t enum {IDLE, REQ, WAIT}.
- Sub-module load_align (combinational): inputs rdata word, addr[1:0], funct3; output extended XLEN data.
- Store lane/be generation stays inline.

## Test plan
- SW addr=0x100, rs2=0xDEADBEEF, gnt immediate -> dmem_addr=0x100, be=1111, we=1, wdata=0xDEADBEEF; done at cycle 2, err=0.
- SB addr=0x103, rs2=0x000000A5 -> be=1000, wdata=0xA5A5A5A5; SH addr=0x102, rs2=0x1234 -> be=1100, wdata=0x12341234.
- Memory word 0x12803456:
  - LB 0x202 -> rdata=0xFFFFFF80.
  - LBU 0x202 -> 0x00000080.
  - LH 0x202 -> 0x00001280.
  - LW 0x200 -> 0x12803456.
- gnt delayed 3 cycles, rvalid 2 cycles after gnt -> req/addr/be stable all 3 cycles; single done at accept+6 with correct data.
- Error cases, each -> no dmem_req, done=err=1 at cycle 1:
  - LW 0x102 -> err_addr=0x102.
  - SH 0x101 -> err_addr=0x101.
  - Load funct3=011 -> err=1.
- rst asserted in WAIT, rvalid 1 cycle later -> dmem_req=0, done=0, ex_ready=1; a new LW 0x0 then completes normally.
